// File: rtl/button_debounce.sv
// Two-flop synchroniser plus per-channel debounce FSM for raw board buttons.
// Emits a clean level and one-cycle press, release and long-press strobes.
module button_debounce #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES - 1);

    localparam logic [1:0] ST_UP      = 2'd0;
    localparam logic [1:0] ST_WAIT_DN = 2'd1;
    localparam logic [1:0] ST_DOWN    = 2'd2;
    localparam logic [1:0] ST_WAIT_UP = 2'd3;

    localparam logic [N_BTN-1:0] IDLE_PIN = {N_BTN{ACTIVE_LOW}};

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] p;

    // Flops idle at the released pin level so reset never looks like a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= IDLE_PIN;
            sync2_q <= IDLE_PIN;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign p = sync2_q ^ IDLE_PIN;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic [1:0]    state_q, state_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [LW-1:0] lcnt_q, lcnt_d;
        logic          done_q, done_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;

        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            lcnt_d  = lcnt_q;
            done_d  = done_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;

            // Long-press timer runs through release bounce; fires once per press
            if (state_q == ST_DOWN || state_q == ST_WAIT_UP) begin
                if (lcnt_q != LMAX) begin
                    lcnt_d = lcnt_q + LW'(1);
                end else if (!done_q) begin
                    long_d = 1'b1;
                    done_d = 1'b1;
                end
            end

            case (state_q)
                ST_UP: begin
                    if (p[g]) begin
                        state_d = ST_WAIT_DN;
                        dcnt_d  = '0;
                    end
                end
                ST_WAIT_DN: begin
                    if (!p[g]) begin
                        state_d = ST_UP;
                    end else if (dcnt_q == DMAX) begin
                        state_d = ST_DOWN;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        lcnt_d  = '0;
                        done_d  = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                ST_DOWN: begin
                    if (!p[g]) begin
                        state_d = ST_WAIT_UP;
                        dcnt_d  = '0;
                    end
                end
                ST_WAIT_UP: begin
                    if (p[g]) begin
                        state_d = ST_DOWN;
                    end else if (dcnt_q == DMAX) begin
                        state_d = ST_UP;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                default: state_d = ST_UP;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_UP;
                dcnt_q  <= '0;
                lcnt_q  <= '0;
                done_q  <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                lcnt_q  <= lcnt_d;
                done_q  <= done_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = rel_q;
        assign btn_long[g]    = long_q;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditioning stage directly upstream of the button/LED logic on the board top level.
- Takes raw, asynchronous, bouncing button pins (B1, B2) and performs three steps per button:
  - synchronises the pin to clk;
  - filters contact bounce with a per-button counter FSM;
  - emits a clean level plus single-cycle press, release and long-press strobes for the downstream consumer.

Parameters:
- N_BTN, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples needed to accept a change (10 ms at 100 MHz); minimum 2.
- LONG_CYCLES, 100000000, cycles in the pressed state before long_press fires (1 s at 100 MHz); must exceed DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board pull-ups); 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- btn_raw  input  N_BTN  raw button pins, asynchronous to clk.
- btn_level  output  N_BTN  debounced state, 1 = pressed.
- btn_press  output  N_BTN  one-cycle strobe on accepted press.
- btn_release  output  N_BTN  one-cycle strobe on accepted release.
- btn_long  output  N_BTN  one-cycle strobe once per press held LONG_CYCLES.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0; FSMs in UP; counters 0.
  - Synchroniser flops reset to the released pin value (1 if ACTIVE_LOW), so no spurious press occurs after reset.
  - Deassertion of reset takes effect on the next clk edge; no other reset path.
- Synchroniser: two flops per channel. p = pin value XOR ACTIVE_LOW, taken after the 2nd flop (1 = pressed). All logic below uses p only.
- Per-channel FSM, 4 states; dcnt is a counter of width clog2(DEBOUNCE_CYCLES):
  - UP: on p=1 go to WAIT_DN and set dcnt=0.
  - WAIT_DN:
    - p=0: back to UP (bounce rejected, no strobe).
    - p=1 and dcnt<DEBOUNCE_CYCLES-1: dcnt++.
    - p=1 and dcnt==DEBOUNCE_CYCLES-1: go to DOWN; btn_level<=1; btn_press pulses for one cycle; lcnt<=0.
  - DOWN: on p=0 go to WAIT_UP and set dcnt=0.
  - WAIT_UP: mirror of WAIT_DN.
    - p=1: back to DOWN.
    - p=0 held: go to UP at dcnt==DEBOUNCE_CYCLES-1; btn_level<=0; btn_release pulses for one cycle.
- Latency: first edge that samples a new stable pin value = edge 1. The strobe and level change are registered on edge DEBOUNCE_CYCLES+3.
- Long press:
  - lcnt (width clog2(LONG_CYCLES)) increments every cycle while the FSM is in DOWN or WAIT_UP.
  - On the cycle lcnt reaches LONG_CYCLES-1, btn_long pulses once. lcnt then saturates; no repeat until the next accepted press.
  - Bounce into WAIT_UP and back does not clear lcnt.
  - btn_long may coincide with the release edge only if both conditions complete on the same cycle; both strobes then assert.
- Strobes are registered and never wider than one cycle.
- btn_press and btn_release are never both 1 on the same channel in the same cycle.
- Channels are fully independent; simultaneous events on different channels are each reported in the same cycle.
- Pin changes shorter than DEBOUNCE_CYCLES stable samples produce no output change.
- Reset mid-debounce or mid-press:
  - everything returns to the reset values;
  - a button held through reset release is re-accepted as a fresh press after DEBOUNCE_CYCLES+3 edges;
  - no release strobe is emitted for the interrupted press.

Test Plan:
- Bench parameters: N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1.
- Clean press: btn_raw[0] 1->0 and held → btn_press[0]=1 for exactly 1 cycle and btn_level[0]=1, both on edge 7; channel 1 outputs stay 0.
- Bounce rejection: btn_raw[0] toggles 0/1 with 2-cycle pulses for 20 cycles, then returns to 1 → btn_level, btn_press and btn_release all stay 0 throughout.
- Release and long press:
  - Hold the press 30 cycles → btn_long[0] pulses once, 16 cycles after btn_press[0], and does not repeat.
  - Release → btn_release[0] single pulse on edge 7 after the pin rises; btn_level[0]=0.
- Simultaneous channels: both pins go to 0 on the same edge → btn_press=2'b11 for one cycle. A later release of channel 1 only → btn_release=2'b10.
- Reset mid-operation: assert rst=0 in WAIT_DN and again in DOWN → outputs immediately 0 asynchronously. With the pin still held at reset release → btn_press re-fires 7 edges later, and no btn_release is emitted.
